// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM state encoding and SPI mode decode helpers.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_t;

    function automatic logic cpol(input int mode);
        return mode[1];
    endfunction

    function automatic logic cpha(input int mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with an extra delay flop for rise/fall pulse detection.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);
    import spi_pkg::*;

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            dly_q  <= RESET_VAL;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~dly_q;
    assign fall     = ~sync_q & dly_q;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// Full-duplex SPI slave, modes 0-3, inputs oversampled in the clk domain.
// Define SPI_SLAVE_OVERRUN_EN for a level RX valid with i_RX_ack and a sticky overrun flag.
//
// state | meaning
// IDLE  | deselected, MISO parked low, bit counter cleared
// LOAD  | one clk: capture i_TX_data into the TX shifter
// SHIFT | selected: sample MOSI / advance MISO on synced SCLK edges
module spi_slave_rx_tx #(
    parameter int SPI_mode   = 0,
    parameter int Data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_SPI_sclk,
    input  logic                  i_SPI_cs,
    input  logic                  i_SPI_mosi,
    input  logic [Data_width-1:0] i_TX_data,
    output logic                  o_SPI_miso,
    output logic                  o_SPI_miso_oe,
    output logic [Data_width-1:0] o_RX_data,
    output logic                  o_RX_valid,
    output logic                  o_TX_load,
    output logic                  o_busy
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    input  logic                  i_RX_ack,
    output logic                  o_RX_overrun
`endif
);
    import spi_pkg::*;

    localparam logic CPOL  = cpol(SPI_mode);
    localparam logic CPHA  = cpha(SPI_mode);
    localparam int   CNT_W = $clog2(Data_width + 1);
    localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(Data_width);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_meta, mosi_sync;
    logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;

    spi_state_t            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [Data_width-1:0] tx_shift;
    logic [Data_width-1:0] rx_shift;
    logic                  drive_en;

    spi_sync_edge #(.RESET_VAL(CPOL)) u_sclk_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (i_SPI_sclk),
        .sync_out (sclk_sync),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (i_SPI_cs),
        .sync_out (cs_sync),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= i_SPI_mosi;
            mosi_sync <= mosi_meta;
        end
    end

    // Leading edge leaves the CPOL idle level, trailing edge returns to it.
    assign sclk_edge   = sclk_rise | sclk_fall;
    assign lead_edge   = sclk_edge & (sclk_sync != CPOL);
    assign trail_edge  = sclk_edge & (sclk_sync == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            drive_en   <= 1'b0;
            o_RX_data  <= '0;
            o_RX_valid <= 1'b0;
            o_TX_load  <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            o_RX_overrun <= 1'b0;
`endif
        end else begin
            o_TX_load <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            if (i_RX_ack)
                o_RX_valid <= 1'b0;
`else
            o_RX_valid <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    bit_cnt  <= '0;
                    drive_en <= 1'b0;
                    if (cs_fall)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    tx_shift  <= i_TX_data;
                    o_TX_load <= 1'b1;
                    drive_en  <= ~CPHA;
                    state     <= cs_rise ? ST_IDLE : ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Completion is seen one clk after the last sample so it wins over a CS rise.
                    if (bit_cnt == WORD_BITS) begin
                        o_RX_data  <= rx_shift;
                        o_RX_valid <= 1'b1;
                        bit_cnt    <= '0;
`ifdef SPI_SLAVE_OVERRUN_EN
                        if (o_RX_valid && !i_RX_ack)
                            o_RX_overrun <= 1'b1;
`endif
                        if (cs_rise) begin
                            state <= ST_IDLE;
                        end else begin
                            tx_shift  <= i_TX_data;
                            o_TX_load <= 1'b1;
                        end
                    end else if (cs_rise) begin
                        state <= ST_IDLE;
                    end else if (sample_edge) begin
                        rx_shift <= {rx_shift[Data_width-2:0], mosi_sync};
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                    end else if (shift_edge) begin
                        // A shift edge before any sample of this word presents the MSB instead of advancing.
                        if (bit_cnt == '0)
                            drive_en <= 1'b1;
                        else
                            tx_shift <= {tx_shift[Data_width-2:0], 1'b0};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_SPI_miso    <= 1'b0;
            o_SPI_miso_oe <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_SPI_miso    <= (state != ST_IDLE) && drive_en && tx_shift[Data_width-1];
            o_SPI_miso_oe <= (state != ST_IDLE);
            o_busy        <= ~cs_sync;
        end
    end

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Bench for spi_slave_rx_tx: one instance per SPI mode driven by a bit-banged master model.
module tb_spi_slave_rx_tx;

    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sclk;
    logic [3:0] cs;
    logic       mosi;
    logic [7:0] tx_data;

    logic [3:0] miso, oe, rx_valid, tx_load, busy;
    logic [7:0] rx_data [4];
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       rx_ack;
    logic [3:0] overrun;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int         vcnt [4];
    int         vhigh [4];
    int         lcnt [4];
    int         vcyc [4];
    logic [7:0] hist [4][64];
    logic [3:0] valid_q = '0;

    logic [7:0] mosi_w [8];
    logic [7:0] tx_w [8];
    logic [7:0] got_w [8];
    logic [7:0] exp_rx [4];
    int         v0, h0, l0, last_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_rx_tx #(.SPI_mode(g), .Data_width(8)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .i_SPI_sclk    (sclk[g]),
            .i_SPI_cs      (cs[g]),
            .i_SPI_mosi    (mosi),
            .i_TX_data     (tx_data),
            .o_SPI_miso    (miso[g]),
            .o_SPI_miso_oe (oe[g]),
            .o_RX_data     (rx_data[g]),
            .o_RX_valid    (rx_valid[g]),
            .o_TX_load     (tx_load[g]),
            .o_busy        (busy[g])
`ifdef SPI_SLAVE_OVERRUN_EN
            ,
            .i_RX_ack      (rx_ack),
            .o_RX_overrun  (overrun[g])
`endif
        );
    end

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rx_valid[m])
                vhigh[m]++;
            if (rx_valid[m] && !valid_q[m]) begin
                hist[m][vcnt[m] % 64] = rx_data[m];
                vcnt[m]++;
                vcyc[m] = cyc;
            end
            if (tx_load[m])
                lcnt[m]++;
            valid_q[m] = rx_valid[m];
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input int m, input int n, input int cut, input int rst_bit);
        logic       pol, pha;
        logic [7:0] word, got;
        int         nb;
        pol = m[1];
        pha = m[0];
        v0 = vcnt[m];
        h0 = vhigh[m];
        l0 = lcnt[m];
        tx_data = tx_w[0];
        @(negedge clk);
        cs[m] = 1'b0;
        repeat (2) @(negedge clk);
        chk($sformatf("m%0d_busy_before_load", m), busy[m], 0);
        @(negedge clk);
        chk($sformatf("m%0d_busy_at_load", m), busy[m], 1);
        repeat (3) @(negedge clk);
        chk($sformatf("m%0d_oe_selected", m), oe[m], 1);
        for (int w = 0; w < n; w++) begin
            nb = (w == n - 1 && cut > 0) ? cut : 8;
            word = mosi_w[w];
            got = '0;
            for (int b = 0; b < nb; b++) begin
                if (w == 0 && b == rst_bit) begin
                    rst = 1'b1;
                    cs[m] = 1'b1;
                    sclk[m] = pol;
                    mosi = 1'b0;
                    #1;
                    chk("rst_miso", miso[m], 0);
                    chk("rst_oe", oe[m], 0);
                    chk("rst_rx_data", rx_data[m], 0);
                    chk("rst_valid", rx_valid[m], 0);
                    chk("rst_tx_load", tx_load[m], 0);
                    chk("rst_busy", busy[m], 0);
                    @(negedge clk);
                    rst = 1'b0;
                    repeat (4) @(negedge clk);
                    return;
                end
                if (!pha) begin
                    mosi = word[7-b];
                    repeat (H) @(negedge clk);
                    sclk[m] = ~pol;
                    got[7-b] = miso[m];
                    last_s = cyc;
                    repeat (H) @(negedge clk);
                    sclk[m] = pol;
                end else begin
                    repeat (H) @(negedge clk);
                    sclk[m] = ~pol;
                    mosi = word[7-b];
                    repeat (H) @(negedge clk);
                    sclk[m] = pol;
                    got[7-b] = miso[m];
                    last_s = cyc;
                end
                if (b == 0 && w + 1 < n)
                    tx_data = tx_w[w+1];
            end
            got_w[w] = got;
        end
        repeat (H) @(negedge clk);
        cs[m] = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_frame(input int m, input int nfull);
        #1;
        chk($sformatf("m%0d_valid_count", m), vcnt[m] - v0, nfull);
        chk($sformatf("m%0d_valid_cycles", m), vhigh[m] - h0, nfull);
        chk($sformatf("m%0d_tx_load_count", m), lcnt[m] - l0, nfull + 1);
        for (int w = 0; w < nfull; w++) begin
            chk($sformatf("m%0d_rx_word%0d", m, w), hist[m][(v0 + w) % 64], mosi_w[w]);
            chk($sformatf("m%0d_miso_word%0d", m, w), got_w[w], tx_w[w]);
        end
        if (nfull > 0) begin
            chk($sformatf("m%0d_valid_latency", m), vcyc[m] - last_s, 4);
            exp_rx[m] = mosi_w[nfull-1];
        end
        chk($sformatf("m%0d_rx_data_held", m), rx_data[m], exp_rx[m]);
        chk($sformatf("m%0d_busy_idle", m), busy[m], 0);
        chk($sformatf("m%0d_oe_idle", m), oe[m], 0);
        chk($sformatf("m%0d_miso_idle", m), miso[m], 0);
    endtask

    initial begin
        int rm, rn;
        rst = 1'b1;
        cs = 4'hF;
        sclk = 4'b1100;
        mosi = 1'b0;
        tx_data = '0;
`ifdef SPI_SLAVE_OVERRUN_EN
        rx_ack = 1'b1;
`endif
        for (int m = 0; m < 4; m++) exp_rx[m] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("m%0d_reset_miso", m), miso[m], 0);
            chk($sformatf("m%0d_reset_oe", m), oe[m], 0);
            chk($sformatf("m%0d_reset_rx_data", m), rx_data[m], 0);
            chk($sformatf("m%0d_reset_valid", m), rx_valid[m], 0);
            chk($sformatf("m%0d_reset_tx_load", m), tx_load[m], 0);
            chk($sformatf("m%0d_reset_busy", m), busy[m], 0);
        end

        mosi_w[0] = 8'hA5; tx_w[0] = 8'h3C;
        run_frame(0, 1, 0, -1);
        check_frame(0, 1);

        mosi_w[0] = 8'($urandom_range(0, 255)); tx_w[0] = 8'($urandom_range(0, 255));
        run_frame(0, 1, 5, -1);
        check_frame(0, 0);
        chk("m0_cut_keeps_a5", rx_data[0], 8'hA5);

        mosi_w[0] = 8'h5A; tx_w[0] = 8'($urandom_range(0, 255));
        run_frame(0, 1, 0, -1);
        check_frame(0, 1);

        mosi_w[0] = 8'h11; mosi_w[1] = 8'h22; mosi_w[2] = 8'h33;
        for (int i = 0; i < 3; i++) tx_w[i] = 8'($urandom_range(0, 255));
        run_frame(0, 3, 0, -1);
        check_frame(0, 3);

        for (int m = 1; m < 4; m++) begin
            mosi_w[0] = 8'h81; tx_w[0] = 8'h7E;
            run_frame(m, 1, 0, -1);
            check_frame(m, 1);
            for (int i = 0; i < 2; i++) begin
                mosi_w[i] = 8'($urandom_range(0, 255));
                tx_w[i] = 8'($urandom_range(0, 255));
            end
            run_frame(m, 2, 0, -1);
            check_frame(m, 2);
        end

        mosi_w[0] = 8'($urandom_range(0, 255)); tx_w[0] = 8'($urandom_range(0, 255));
        run_frame(0, 1, 0, 4);
        #1;
        for (int m = 0; m < 4; m++) begin
            exp_rx[m] = '0;
            chk($sformatf("m%0d_rx_data_after_rst", m), rx_data[m], 0);
        end
        mosi_w[0] = 8'hC3; tx_w[0] = 8'($urandom_range(0, 255));
        run_frame(0, 1, 0, -1);
        check_frame(0, 1);

        for (int k = 0; k < 4; k++) begin
            rm = $urandom_range(0, 3);
            rn = $urandom_range(1, 3);
            for (int i = 0; i < rn; i++) begin
                mosi_w[i] = 8'($urandom_range(0, 255));
                tx_w[i] = 8'($urandom_range(0, 255));
            end
            run_frame(rm, rn, 0, -1);
            check_frame(rm, rn);
        end

`ifdef SPI_SLAVE_OVERRUN_EN
        @(negedge clk);
        rx_ack = 1'b0;
        mosi_w[0] = 8'($urandom_range(0, 255)); mosi_w[1] = 8'($urandom_range(0, 255));
        tx_w[0] = 8'($urandom_range(0, 255)); tx_w[1] = 8'($urandom_range(0, 255));
        run_frame(0, 2, 0, -1);
        #1;
        chk("ovr_flag_set", overrun[0], 1);
        chk("ovr_rx_data_second", rx_data[0], mosi_w[1]);
        chk("ovr_valid_level", rx_valid[0], 1);
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        #1;
        chk("ovr_ack_clears_valid", rx_valid[0], 0);
        chk("ovr_flag_sticky", overrun[0], 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
